// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding,
// bus widths and the access-counter helper.
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_ACC  = 3'd1,
    P_DONE = 3'd2,
    D_ACC  = 3'd3,
    D_DONE = 3'd4
  } state_t;

  // Counter value that marks the final cycle of an access of the given length.
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates Data_memory between the MEM-stage pipeline port and a debug port.
// Debug port is built only when DMEM_ARB_DEBUG_EN is defined; otherwise its outputs are tied to 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_memread,
  input  logic              p_memwrite,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_memread,
  output logic              m_memwrite,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [CNT_W-1:0] LAST_CNT = last_count(ACCESS_CYCLES);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_p_rdata;

  logic w_p_req;
  logic w_in_acc;
  logic w_last;

  assign w_p_req  = p_memread | p_memwrite;
  assign w_in_acc = (r_state == P_ACC) || (r_state == D_ACC);
  assign w_last   = w_in_acc && (r_cnt == LAST_CNT);

`ifdef DMEM_ARB_DEBUG_EN
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_d_wins;

  // Debug wins when it is alone, or when the pipeline has used up its run of grants.
  assign w_d_wins = d_req && (!w_p_req || (r_starve_cnt == STARVE_MAX));
`else
  logic w_unused_dbg;
  assign w_unused_dbg = ^{d_req, d_we, d_addr, d_wdata};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_p_rdata <= '0;
`ifdef DMEM_ARB_DEBUG_EN
      r_starve_cnt <= '0;
      r_d_rdata    <= '0;
`endif
    end else begin
      r_cnt <= (w_in_acc && !w_last) ? r_cnt + 4'd1 : '0;
      case (r_state)
        IDLE: begin
`ifdef DMEM_ARB_DEBUG_EN
          if (w_d_wins) begin
            r_state      <= D_ACC;
            r_addr       <= d_addr;
            r_wdata      <= d_wdata;
            r_rd         <= !d_we;
            r_wr         <= d_we;
            r_starve_cnt <= '0;
          end else if (w_p_req) begin
            r_state <= P_ACC;
            r_addr  <= p_addr;
            r_wdata <= p_wdata;
            r_rd    <= p_memread;
            r_wr    <= p_memwrite;
            if (!d_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else begin
            r_starve_cnt <= '0;
          end
`else
          if (w_p_req) begin
            r_state <= P_ACC;
            r_addr  <= p_addr;
            r_wdata <= p_wdata;
            r_rd    <= p_memread;
            r_wr    <= p_memwrite;
          end
`endif
        end
        P_ACC: begin
          if (w_last) begin
            r_state   <= P_DONE;
            r_p_rdata <= m_rdata;
          end
        end
        P_DONE: r_state <= IDLE;
`ifdef DMEM_ARB_DEBUG_EN
        D_ACC: begin
          if (w_last) begin
            r_state   <= D_DONE;
            r_d_rdata <= m_rdata;
          end
        end
        D_DONE: r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_addr     = w_in_acc ? r_addr : '0;
  assign m_wdata    = w_in_acc ? r_wdata : '0;
  assign m_memread  = w_in_acc && r_rd;
  // Reset must suppress the single write strobe even when it lands on the final cycle.
  assign m_memwrite = w_last && r_wr && !reset;

  assign p_rdata = r_p_rdata;
  assign p_stall = w_p_req && (r_state != P_DONE);

`ifdef DMEM_ARB_DEBUG_EN
  assign d_gnt   = (r_state == D_ACC);
  assign d_valid = (r_state == D_DONE);
  assign d_rdata = r_d_rdata;
`else
  assign d_gnt   = 1'b0;
  assign d_valid = 1'b0;
  assign d_rdata = '0;
`endif

endmodule
